// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - load/store stage between EX and WB with a single outstanding dmem access; optional MEM_TIMEOUT_EN response timeout
module memory_access_unit #(
    parameter int XLEN    = 32,
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [XLEN-1:0]     ex_alu_out,
    input  logic [XLEN-1:0]     ex_mem_data,
    input  logic [OP_W-1:0]     ex_opcode,
    input  logic [REG_W-1:0]    ex_rf_dest,
    input  logic                ex_load,
    input  logic                ex_store,
    input  logic [2:0]          ex_mode,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [XLEN-1:0]     mem_pc,
    output logic [XLEN-1:0]     mem_alu_out,
    output logic [XLEN-1:0]     mem_out,
    output logic [OP_W-1:0]     mem_opcode,
    output logic [REG_W-1:0]    mem_rf_dest,
    output logic                mem_fault,
    output logic                dmem_req,
    input  logic                dmem_gnt,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN/8-1:0]   dmem_be,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state_q;
    logic              mem_valid_q;
    logic [XLEN-1:0]   mem_pc_q;
    logic [XLEN-1:0]   mem_alu_out_q;
    logic [XLEN-1:0]   mem_out_q;
    logic [OP_W-1:0]   mem_opcode_q;
    logic [REG_W-1:0]  mem_rf_dest_q;
    logic              mem_fault_q;
    logic [2:0]        mode_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [XLEN-1:0]   dmem_addr_q;
    logic [NB-1:0]     dmem_be_q;
    logic [XLEN-1:0]   dmem_wdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     tmo_q;
`endif

    // Decoded request for the op currently offered by EX
    logic              ex_is_mem;
    logic              ex_misal;
    logic [NB-1:0]     be_mask;
    logic [NB-1:0]     be_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   addr_d;

    // Size decode: alignment, lane mask and lane-replicated store data
    always_comb begin
        ex_is_mem = ex_load ^ ex_store;
        ex_misal  = 1'b0;
        be_mask   = '0;
        wdata_d   = ex_mem_data;
        case (ex_mode[1:0])
            2'b00: begin
                be_mask = NB'(1);
                wdata_d = {NB{ex_mem_data[7:0]}};
            end
            2'b01: begin
                ex_misal = ex_alu_out[0];
                be_mask  = NB'(3);
                wdata_d  = {(NB/2){ex_mem_data[15:0]}};
            end
            2'b10: begin
                ex_misal = |ex_alu_out[1:0];
                be_mask  = NB'(15);
                wdata_d  = {(NB/4){ex_mem_data[31:0]}};
            end
            default: begin
                // A doubleword only exists on a 64-bit datapath
                ex_misal = (XLEN == 64) ? |ex_alu_out[2:0] : 1'b1;
                be_mask  = {NB{1'b1}};
                wdata_d  = ex_mem_data;
            end
        endcase
        be_d   = be_mask << ex_alu_out[OFFW-1:0];
        addr_d = {ex_alu_out[XLEN-1:OFFW], {OFFW{1'b0}}};
    end

    // Load data: shift the addressed lane down, then sign- or zero-extend
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   ld_mask;
    logic              ld_sbit;
    logic [XLEN-1:0]   load_d;

    always_comb begin
        rd_shift = dmem_rdata >> {mem_alu_out_q[OFFW-1:0], 3'b000};
        case (mode_q[1:0])
            2'b00:   begin ld_mask = XLEN'(8'hFF);         ld_sbit = rd_shift[7];  end
            2'b01:   begin ld_mask = XLEN'(16'hFFFF);      ld_sbit = rd_shift[15]; end
            2'b10:   begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sbit = rd_shift[31]; end
            default: begin ld_mask = '1;                   ld_sbit = 1'b0;         end
        endcase
        load_d = (rd_shift & ld_mask) | ((ld_sbit && !mode_q[2]) ? ~ld_mask : '0);
    end

    // Access FSM; every output to WB and dmem is registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_valid_q   <= 1'b0;
            mem_pc_q      <= '0;
            mem_alu_out_q <= '0;
            mem_out_q     <= '0;
            mem_opcode_q  <= '0;
            mem_rf_dest_q <= '0;
            mem_fault_q   <= 1'b0;
            mode_q        <= '0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_be_q     <= '0;
            dmem_wdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        mem_pc_q      <= ex_pc;
                        mem_alu_out_q <= ex_alu_out;
                        mem_opcode_q  <= ex_opcode;
                        mem_rf_dest_q <= ex_rf_dest;
                        mode_q        <= ex_mode;
                        mem_out_q     <= '0;
                        mem_fault_q   <= 1'b0;
                        if (!ex_is_mem) begin
                            state_q     <= HOLD;
                            mem_valid_q <= 1'b1;
                        end else if (ex_misal) begin
                            state_q     <= HOLD;
                            mem_valid_q <= 1'b1;
                            mem_fault_q <= 1'b1;
                        end else begin
                            state_q      <= REQ;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= ex_store;
                            dmem_addr_q  <= addr_d;
                            dmem_be_q    <= be_d;
                            dmem_wdata_q <= wdata_d;
`ifdef MEM_TIMEOUT_EN
                            tmo_q        <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_q     <= HOLD;
                        mem_valid_q <= 1'b1;
                        if (dmem_err) begin
                            mem_fault_q <= 1'b1;
                            mem_out_q   <= '0;
                        end else begin
                            mem_out_q   <= dmem_we_q ? '0 : load_d;
                        end
                    end
                end
                HOLD: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef MEM_TIMEOUT_EN
            // A response arriving in the same cycle wins over the timeout
            if (state_q == REQ || (state_q == WAIT && !dmem_rvalid)) begin
                if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_q     <= HOLD;
                    dmem_req_q  <= 1'b0;
                    mem_valid_q <= 1'b1;
                    mem_fault_q <= 1'b1;
                    mem_out_q   <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
`endif
        end
    end

    assign ex_ready    = (state_q == IDLE);
    assign mem_valid   = mem_valid_q;
    assign mem_pc      = mem_pc_q;
    assign mem_alu_out = mem_alu_out_q;
    assign mem_out     = mem_out_q;
    assign mem_opcode  = mem_opcode_q;
    assign mem_rf_dest = mem_rf_dest_q;
    assign mem_fault   = mem_fault_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_be     = dmem_be_q;
    assign dmem_wdata  = dmem_wdata_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - scoreboard bench for memory_access_unit with dmem responder and WB monitor
module tb_memory_access_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_alu_out, ex_mem_data;
    logic [5:0]  ex_opcode;
    logic [4:0]  ex_rf_dest;
    logic        ex_load, ex_store;
    logic [2:0]  ex_mode;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_pc, mem_alu_out, mem_out;
    logic [5:0]  mem_opcode;
    logic [4:0]  mem_rf_dest;
    logic        mem_fault;
    logic        dmem_req, dmem_gnt, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    memory_access_unit dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out),
        .ex_mem_data(ex_mem_data), .ex_opcode(ex_opcode), .ex_rf_dest(ex_rf_dest),
        .ex_load(ex_load), .ex_store(ex_store), .ex_mode(ex_mode),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc), .mem_alu_out(mem_alu_out),
        .mem_out(mem_out), .mem_opcode(mem_opcode), .mem_rf_dest(mem_rf_dest), .mem_fault(mem_fault),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    typedef struct {
        logic [31:0] pc, alu, data, rdata;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        load, store, err, hang, no_result;
        logic [2:0]  mode;
        int          gnt_dly, rv_dly, stall;
    } op_t;

    typedef struct {
        logic [31:0] pc, alu, out;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic        fault;
        int          stall;
    } exp_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        we;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err, hang;
        int          gnt_dly, rv_dly;
    } plan_t;

    exp_t  exp_q[$];
    req_t  req_q[$];
    plan_t plan_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t base_op();
        op_t o;
        o.pc = $urandom; o.alu = 32'h0; o.data = $urandom; o.rdata = $urandom;
        o.op = 6'($urandom); o.rd = 5'($urandom);
        o.load = 1'b0; o.store = 1'b0; o.err = 1'b0; o.hang = 1'b0; o.no_result = 1'b0;
        o.mode = 3'b010; o.gnt_dly = 0; o.rv_dly = 0; o.stall = 0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  r;
        o = base_op();
        r = $urandom % 8;
        o.load  = (r == 1) || (r >= 2 && r <= 4);
        o.store = (r == 1) || (r >= 5);
        o.alu   = $urandom & 32'h0000_0FFF;
        if ($urandom % 2 == 1) o.alu[1:0] = 2'b00;
        o.mode    = 3'($urandom);
        o.err     = ($urandom % 6 == 0);
        o.gnt_dly = $urandom % 4;
        o.rv_dly  = $urandom % 4;
        o.stall   = $urandom % 3;
        return o;
    endfunction

    // Reference model: derive the expected WB result and dmem request, then hand the op to the DUT
    task automatic do_op(input op_t o, output int xfer_cyc);
        exp_t   e;
        req_t   r;
        plan_t  p;
        logic   is_mem, mis;
        int     size, off, n;
        longint mask, v;
        size   = 1 << o.mode[1:0];
        off    = int'(o.alu[1:0]);
        is_mem = (o.load != o.store);
        mis    = is_mem && (size > 4 || (o.alu % size) != 0);
        mask   = (64'd1 << (8 * size)) - 1;
        v      = ({32'd0, o.rdata} >> (8 * off)) & mask;
        if (!o.mode[2] && v[8 * size - 1]) v = v | ~mask;
        e.pc = o.pc; e.alu = o.alu; e.op = o.op; e.rd = o.rd; e.stall = o.stall;
        e.fault = mis || (is_mem && o.err);
        e.out   = (is_mem && !mis && o.load && !o.err) ? v[31:0] : 32'd0;
        if (!o.no_result) exp_q.push_back(e);
        if (is_mem && !mis) begin
            r.addr  = o.alu & ~32'h3;
            r.be    = 4'(((1 << size) - 1) << off);
            r.we    = o.store;
            r.wdata = '0;
            for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = o.data[8*(k % size) +: 8];
            req_q.push_back(r);
            p.rdata = o.rdata; p.err = o.err; p.hang = o.hang;
            p.gnt_dly = o.gnt_dly; p.rv_dly = o.rv_dly;
            plan_q.push_back(p);
        end
        ex_pc = o.pc; ex_alu_out = o.alu; ex_mem_data = o.data; ex_opcode = o.op;
        ex_rf_dest = o.rd; ex_load = o.load; ex_store = o.store; ex_mode = o.mode;
        ex_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ex_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) check("xfer_timeout", ex_ready, 1);
        @(posedge clk);
        #1;
        xfer_cyc = cyc;
        ex_valid = 1'b0;
        if (!is_mem || mis) begin
            check("lat_valid", mem_valid, 1);
            check("no_req", dmem_req, 0);
        end else begin
            check("req_entry", dmem_req, 1);
        end
    endtask

    // dmem responder: checks each request, stalls the grant, returns the planned response
    initial begin
        plan_t       p;
        req_t        r;
        int          n, k;
        logic [31:0] s_addr, s_wdata;
        logic [4:0]  s_bewe;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_err = 0; dmem_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dmem_gnt = 0; dmem_rvalid = 0;
            end else if (!dmem_req) begin
                dmem_rvalid = 1'($urandom % 2);
                dmem_err    = 1'($urandom % 2);
                dmem_rdata  = $urandom;
            end else if (plan_q.size() == 0) begin
                check("unexp_req", dmem_req, 0);
                dmem_rvalid = 0;
            end else begin
                p = plan_q.pop_front();
                r = req_q.pop_front();
                n = 1;
                check("req_addr", dmem_addr, r.addr);
                check("req_be", dmem_be, r.be);
                check("req_we", dmem_we, r.we);
                if (r.we) check("req_wdata", dmem_wdata, r.wdata);
                s_addr = dmem_addr; s_wdata = dmem_wdata; s_bewe = {dmem_be, dmem_we};
                for (int i = 0; i < p.gnt_dly; i++) begin
                    dmem_gnt    = 0;
                    dmem_rvalid = 1'($urandom % 2);
                    dmem_err    = 1'($urandom % 2);
                    @(negedge clk);
                    if (dmem_req) n++;
                    check("req_stable_addr", {dmem_addr, dmem_wdata}, {s_addr, s_wdata});
                    check("req_stable_be", {dmem_be, dmem_we}, s_bewe);
                end
                dmem_rvalid = 0;
                dmem_gnt    = 1;
                @(posedge clk);
                #1;
                dmem_gnt = 0;
                check("req_cycles", n, p.gnt_dly + 1);
                if (p.hang) begin
                    k = 0;
                    while (!ex_ready && k < 300) begin
                        @(negedge clk);
                        k++;
                    end
                end else begin
                    repeat (p.rv_dly) begin
                        @(posedge clk);
                        #1;
                    end
                    dmem_rvalid = 1; dmem_err = p.err; dmem_rdata = p.rdata;
                    @(posedge clk);
                    #1;
                    dmem_rvalid = 0; dmem_err = 0;
                end
            end
        end
    end

    // WB monitor: stalls per the op's plan, checks hold stability, pops and compares on handshake
    initial begin
        bit          have_snap;
        int          stall_left;
        exp_t        e;
        logic [95:0] s0, s1;
        have_snap = 0; stall_left = 0; mem_ready = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_snap = 0;
                mem_ready = 0;
            end else if (!mem_valid) begin
                mem_ready = 1'($urandom % 2);
            end else if (exp_q.size() == 0) begin
                check("unexp_valid", mem_valid, 0);
                mem_ready = 1;
            end else begin
                if (!have_snap) begin
                    have_snap  = 1;
                    stall_left = exp_q[0].stall;
                    s0 = {mem_pc, mem_alu_out, mem_out};
                    s1 = 96'({mem_opcode, mem_rf_dest, mem_fault});
                end else begin
                    check("hold_data", {mem_pc, mem_alu_out, mem_out}, s0);
                    check("hold_ctrl", 96'({mem_opcode, mem_rf_dest, mem_fault}), s1);
                end
                check("ex_ready_hold", ex_ready, 0);
                if (stall_left > 0) begin
                    mem_ready = 0;
                    stall_left--;
                end else begin
                    e = exp_q.pop_front();
                    check("wb_pc", mem_pc, e.pc);
                    check("wb_alu", mem_alu_out, e.alu);
                    check("wb_out", mem_out, e.out);
                    check("wb_opcode", mem_opcode, e.op);
                    check("wb_rd", mem_rf_dest, e.rd);
                    check("wb_fault", mem_fault, e.fault);
                    mem_ready = 1;
                    have_snap = 0;
                end
            end
        end
    end

    initial begin
        op_t o;
        int  t0, t1, k;
        rst = 1; ex_valid = 0; ex_pc = 0; ex_alu_out = 0; ex_mem_data = 0;
        ex_opcode = 0; ex_rf_dest = 0; ex_load = 0; ex_store = 0; ex_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ex_ready", ex_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_mem_fault", mem_fault, 0);
        check("rst_mem_data", {mem_pc, mem_alu_out, mem_out}, 96'd0);
        check("rst_dmem_data", {dmem_addr, dmem_wdata, 28'd0, dmem_be}, 96'd0);
        check("rst_mem_ctrl", {mem_opcode, mem_rf_dest}, 0);
        rst = 0;
        @(posedge clk);
        #1;

        // Non-memory ops back to back
        o = base_op(); o.alu = 32'h1234;
        do_op(o, t0);
        check("nonmem_alu_now", mem_alu_out, 32'h1234);
        o = base_op(); o.alu = 32'h5678; o.load = 1; o.store = 1;
        do_op(o, t1);
        check("nonmem_throughput", t1 - t0, 2);

        // Byte loads from the top lane, signed then unsigned
        o = base_op(); o.load = 1; o.alu = 32'h103; o.mode = 3'b000; o.rdata = 32'h80AABBCC;
        do_op(o, t0);
        o.mode = 3'b100; o.rv_dly = 2;
        do_op(o, t0);

        // Half store with a late grant
        o = base_op(); o.store = 1; o.alu = 32'h202; o.mode = 3'b001; o.data = 32'h0000BEEF; o.gnt_dly = 3;
        do_op(o, t0);

        // Misaligned word, dword on a 32-bit datapath, and a bus error
        o = base_op(); o.load = 1; o.alu = 32'h6; o.mode = 3'b010;
        do_op(o, t0);
        o = base_op(); o.store = 1; o.alu = 32'h10; o.mode = 3'b011;
        do_op(o, t0);
        o = base_op(); o.load = 1; o.alu = 32'h8; o.mode = 3'b010; o.err = 1; o.rv_dly = 1;
        do_op(o, t0);

        // WB back-pressure for five cycles
        o = base_op(); o.alu = 32'hCAFE; o.stall = 5;
        do_op(o, t0);
        o = base_op(); o.load = 1; o.alu = 32'h44; o.mode = 3'b001; o.stall = 5;
        do_op(o, t0);

        for (int i = 0; i < 150; i++) begin
            o = rand_op();
            do_op(o, t0);
        end

        // Reset while waiting for the response, then stray responses
        o = base_op(); o.load = 1; o.alu = 32'h40; o.gnt_dly = 1; o.hang = 1; o.no_result = 1;
        do_op(o, t0);
        k = 0;
        while (dmem_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("req_drop", dmem_req, 0);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        check("async_rst_ready", ex_ready, 1);
        check("async_rst_req", dmem_req, 0);
        check("async_rst_valid", mem_valid, 0);
        check("async_rst_data", {mem_pc, mem_alu_out, mem_out}, 96'd0);
        @(posedge clk);
        #1;
        rst = 0;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_valid", mem_valid, 0);
            check("post_rst_ready", ex_ready, 1);
        end
        @(posedge clk);
        #1;
        o = base_op(); o.load = 1; o.alu = 32'h52; o.mode = 3'b101; o.rdata = 32'h8001_7FFF;
        do_op(o, t0);

`ifdef MEM_TIMEOUT_EN
        o = base_op(); o.load = 1; o.alu = 32'h80; o.gnt_dly = 2; o.hang = 1; o.err = 1;
        do_op(o, t0);
        k = 0;
        while (!mem_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("timeout_cycles", k, 15);
        check("timeout_req", dmem_req, 0);
`endif

        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
